// File: rtl/if_skid_reg.sv
// PreIF->IF fetch-bundle register with optional two-entry skid; beats with no valid lane are dropped.
// Latency: 1 cycle from accept to out_valid; retire and accept may overlap for 1 beat/cycle.
// Backpressure: SKID=1 drives in_ready from the skid flop only; SKID=0 uses !main.valid || out_ready.
module if_skid_reg #(
    parameter int PC_W  = 32,
    parameter int EXC_W = 8,
    parameter int LANES = 2,
    parameter int SKID  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*PC_W-1:0]  in_pc,
    input  logic [LANES*EXC_W-1:0] in_exc,
    input  logic [LANES-1:0]       in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*PC_W-1:0]  out_pc,
    output logic [LANES*EXC_W-1:0] out_exc,
    output logic [LANES-1:0]       out_mask,
    output logic [1:0]             occupancy
);

    typedef struct packed {
        logic [LANES*PC_W-1:0]  pc;
        logic [LANES*EXC_W-1:0] exc;
        logic [LANES-1:0]       mask;
        logic                   valid;
    } entry_t;

    entry_t main_q, main_nxt;
    entry_t skid_q, skid_nxt;
    entry_t in_ent;

    logic accept;
    logic retire;
    logic store;

    assign in_ent = {in_pc, in_exc, in_mask, 1'b1};

    assign in_ready = (SKID != 0) ? !skid_q.valid : (!main_q.valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign retire   = main_q.valid && out_ready;
    // An all-lanes-invalid beat completes its handshake but never occupies an entry.
    assign store    = accept && (|in_mask);

    always_comb begin
        main_nxt = main_q;
        skid_nxt = skid_q;
        if (SKID != 0) begin
            if (skid_q.valid) begin
                if (retire) begin
                    main_nxt = skid_q;
                    skid_nxt = '0;
                end
            end else if (main_q.valid) begin
                if (retire) begin
                    if (store) begin
                        main_nxt = in_ent;
                    end else begin
                        main_nxt.valid = 1'b0;
                    end
                end else if (store) begin
                    skid_nxt = in_ent;
                end
            end else if (store) begin
                main_nxt = in_ent;
            end
        end else begin
            // Accepting into a full main entry implies out_ready, so the old head retires.
            if (store) begin
                main_nxt = in_ent;
            end else if (retire) begin
                main_nxt.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    assign out_valid = main_q.valid;
    assign out_pc    = main_q.pc;
    assign out_exc   = main_q.exc;
    assign out_mask  = main_q.mask;
    assign occupancy = {1'b0, main_q.valid} + {1'b0, skid_q.valid};

endmodule

// File: tb/tb_if_skid_reg.sv
// Directed bench: SKID=1 and SKID=0 instances share stimulus; each test checks one of them.
module tb_if_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [15:0] in_exc;
    logic [1:0]  in_mask;
    logic        out_ready;

    logic        s_in_ready, s_out_valid;
    logic [63:0] s_out_pc;
    logic [15:0] s_out_exc;
    logic [1:0]  s_out_mask, s_occ;

    logic        r_in_ready, r_out_valid;
    logic [63:0] r_out_pc;
    logic [15:0] r_out_exc;
    logic [1:0]  r_out_mask, r_occ;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_skid_reg #(.PC_W(32), .EXC_W(8), .LANES(2), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_pc(in_pc), .in_exc(in_exc), .in_mask(in_mask),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pc(s_out_pc), .out_exc(s_out_exc), .out_mask(s_out_mask),
        .occupancy(s_occ)
    );

    if_skid_reg #(.PC_W(32), .EXC_W(8), .LANES(2), .SKID(0)) u_reg (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r_in_ready),
        .in_pc(in_pc), .in_exc(in_exc), .in_mask(in_mask),
        .out_valid(r_out_valid), .out_ready(out_ready),
        .out_pc(r_out_pc), .out_exc(r_out_exc), .out_mask(r_out_mask),
        .occupancy(r_occ)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pc_pair(input logic [31:0] base);
        logic [31:0] hi;
        hi = base + 32'd4;
        return {hi, base};
    endfunction

    task automatic offer(input logic [31:0] base);
        in_valid = 1'b1;
        in_pc    = pc_pair(base);
        in_exc   = 16'h0000;
        in_mask  = 2'b11;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        mdl_vld;
        logic [63:0] mdl_pc;
        logic        exp_rdy;
        int          k;
        int          delivered;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_exc = '0;
        in_mask = '0; out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_s_ovld", 64'(s_out_valid), 64'd0);
        chk("rst_s_occ",  64'(s_occ), 64'd0);
        chk("rst_s_pc",   s_out_pc, 64'd0);
        chk("rst_s_irdy", 64'(s_in_ready), 64'd1);
        chk("rst_r_irdy", 64'(r_in_ready), 64'd1);
        chk("rst_r_ovld", 64'(r_out_valid), 64'd0);

        // Streaming at one beat per cycle through both variants.
        in_valid = 1'b1; in_pc = 64'hBFC00004_BFC00000; in_mask = 2'b11; in_exc = '0;
        out_ready = 1'b1;
        repeat (4) begin
            cyc();
            chk("str_s_ovld", 64'(s_out_valid), 64'd1);
            chk("str_s_pc",   s_out_pc, 64'hBFC00004_BFC00000);
            chk("str_s_mask", 64'(s_out_mask), 64'd3);
            chk("str_s_occ",  64'(s_occ), 64'd1);
            chk("str_s_irdy", 64'(s_in_ready), 64'd1);
            chk("str_r_ovld", 64'(r_out_valid), 64'd1);
            chk("str_r_pc",   r_out_pc, 64'hBFC00004_BFC00000);
        end
        in_valid = 1'b0;
        cyc();
        chk("drain_s_occ", 64'(s_occ), 64'd0);

        // Fill the skid under backpressure, then drain in order.
        out_ready = 1'b0;
        offer(32'h100);
        #1 chk("A_irdy", 64'(s_in_ready), 64'd1);
        cyc();
        offer(32'h108);
        #1 chk("B_irdy", 64'(s_in_ready), 64'd1);
        cyc();
        offer(32'h110);
        #1 chk("C_irdy0", 64'(s_in_ready), 64'd0);
        chk("full_occ", 64'(s_occ), 64'd2);
        cyc();
        chk("hold_occ", 64'(s_occ), 64'd2);
        chk("hold_pcA", s_out_pc, pc_pair(32'h100));
        out_ready = 1'b1;
        cyc();
        chk("dlv_pcB",  s_out_pc, pc_pair(32'h108));
        chk("dlv_occB", 64'(s_occ), 64'd1);
        chk("C_irdy1",  64'(s_in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        chk("dlv_pcC",  s_out_pc, pc_pair(32'h110));
        chk("dlv_vldC", 64'(s_out_valid), 64'd1);
        cyc();
        chk("dlv_done", 64'(s_out_valid), 64'd0);

        // Flush at full occupancy discards both entries and the offered beat.
        out_ready = 1'b0;
        offer(32'h100);
        cyc();
        offer(32'h108);
        cyc();
        chk("fl_pre_occ", 64'(s_occ), 64'd2);
        flush = 1'b1;
        offer(32'h300);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_ovld", 64'(s_out_valid), 64'd0);
        chk("fl_occ",  64'(s_occ), 64'd0);
        chk("fl_pc",   s_out_pc, 64'd0);
        chk("fl_irdy", 64'(s_in_ready), 64'd1);
        cyc();
        chk("fl_ghost", 64'(s_out_valid), 64'd0);

        // Empty-mask beat handshakes but is not stored.
        out_ready = 1'b1;
        offer(32'h200);
        in_mask = 2'b00;
        #1 chk("m0_irdy", 64'(s_in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        chk("m0_ovld", 64'(s_out_valid), 64'd0);
        chk("m0_occ",  64'(s_occ), 64'd0);

        // Reset at full occupancy, then exception bundle pass-through.
        out_ready = 1'b0;
        offer(32'h100);
        cyc();
        offer(32'h108);
        cyc();
        chk("rs_pre_occ", 64'(s_occ), 64'd2);
        in_valid = 1'b0;
        do_reset();
        chk("rs_ovld", 64'(s_out_valid), 64'd0);
        chk("rs_pc",   s_out_pc, 64'd0);
        chk("rs_exc",  64'(s_out_exc), 64'd0);
        chk("rs_mask", 64'(s_out_mask), 64'd0);
        chk("rs_occ",  64'(s_occ), 64'd0);
        chk("rs_irdy", 64'(s_in_ready), 64'd1);
        offer(32'h400);
        in_exc = 16'h0004; in_mask = 2'b01;
        cyc();
        in_valid = 1'b0;
        chk("exc_val",  64'(s_out_exc), 64'h0004);
        chk("exc_mask", 64'(s_out_mask), 64'd1);
        chk("exc_pc",   s_out_pc, pc_pair(32'h400));

        // SKID=0: alternating out_ready, 8 beats, combinational ready.
        out_ready = 1'b0;
        do_reset();
        mdl_vld = 1'b0; mdl_pc = '0; k = 0; delivered = 0;
        for (int c = 0; c < 40 && delivered < 8; c++) begin
            out_ready = (c % 2 == 0);
            if (k < 8) offer(32'h500 + 32'(k) * 32'd8);
            else in_valid = 1'b0;
            #1;
            exp_rdy = !mdl_vld || out_ready;
            chk("r_ovld", 64'(r_out_valid), 64'(mdl_vld));
            chk("r_irdy", 64'(r_in_ready), 64'(exp_rdy));
            if (mdl_vld) chk("r_pc", r_out_pc, mdl_pc);
            if (mdl_vld && out_ready) begin
                chk("r_order", r_out_pc, pc_pair(32'h500 + 32'(delivered) * 32'd8));
                delivered++;
            end
            if (in_valid && exp_rdy) begin
                mdl_vld = 1'b1;
                mdl_pc  = in_pc;
                k++;
            end else if (mdl_vld && out_ready) begin
                mdl_vld = 1'b0;
            end
            cyc();
        end
        chk("r_count", 64'(delivered), 64'd8);
        chk("r_occ_end", 64'(r_occ), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_skid_reg.md
Name: if_skid_reg

Overview:
- Parametrised successor to the single-lane fetch-stage pipeline register.
- Carries a LANES-wide fetch bundle (PC and exception bundle per lane, plus a lane-valid mask) between PreIF and IF using a valid/ready handshake instead of a write-enable.
- An optional skid entry lets in_ready be driven from a flop, which breaks the combinational ready path from the decoder back to the PC generator.
- Synchronous flush discards all buffered beats.

Parameters:
- PC_W, 32, width of one lane's PC.
- EXC_W, 8, width of one lane's exception bundle.
- LANES, 2, fetch lanes per beat (>=1).
- SKID, 1: 1 = two-entry skid (registered in_ready); 0 = single register (combinational in_ready).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous flush, active-high
- in_valid  in  1  upstream beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_pc  in  LANES*PC_W  lane i at bits [i*PC_W +: PC_W]
- in_exc  in  LANES*EXC_W  per-lane exception bundle
- in_mask  in  LANES  per-lane valid
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts
- out_pc  out  LANES*PC_W  head PC bundle
- out_exc  out  LANES*EXC_W  head exception bundle
- out_mask  out  LANES  head lane mask
- occupancy  out  2  buffered beats (0..2; max 1 when SKID=0)

Behaviour:
- Storage: main entry (head, drives out_*) and, if SKID=1, a skid entry. Each entry holds {pc, exc, mask, valid}.
- Handshake events:
  - accept = in_valid && in_ready.
  - retire = out_valid && out_ready.
  - Payload is sampled only on accept.
  - Beats leave in arrival order.
- Accepted beat with in_mask == 0: the handshake completes, but the beat is dropped (not stored, occupancy unchanged).
- SKID=1 states, by occupancy:
  - EMPTY: in_ready=1. accept -> ONE (beat into main).
  - ONE: in_ready=1.
    - accept && retire -> ONE (new beat replaces main).
    - accept && !retire -> TWO (beat into skid).
    - retire only -> EMPTY.
  - TWO: in_ready=0.
    - retire -> ONE (skid moves to main, skid cleared).
    - otherwise hold.
- SKID=1 ready rule: in_ready = !skid.valid, from flops only. It has no combinational dependence on out_ready or in_valid.
- SKID=0:
  - in_ready = !main.valid || out_ready (combinational).
  - accept loads main; retire without accept clears main.valid.
- Output timing:
  - out_valid = main.valid.
  - out_* are driven directly from the main flops.
  - Latency from accept to out_valid is 1 cycle.
  - While out_valid && !out_ready, out_pc/out_exc/out_mask hold stable.
- Reset (rst=1 at clk edge):
  - All entries cleared: pc, exc and mask all 0, valid=0.
  - out_valid=0, out_pc=0, out_exc=0, out_mask=0, occupancy=0.
  - in_ready=1 from the first cycle after reset.
- Flush (flush=1 at clk edge):
  - Same effect as reset on all state.
  - The beat offered in the flush cycle is discarded, even if in_ready=1.
  - A retire in the same cycle still counts downstream; flush takes priority for the next state.
- Priority: rst = flush > retire/accept.
- Reset or flush mid-operation (occupancy=2) returns to EMPTY in one cycle.
- occupancy = main.valid + skid.valid. It is never 3, and never 2 when SKID=0.
- No lane compaction: out_mask is the stored mask exactly as received.

Test Plan:
- Reset, then in_valid=1, pc={0xBFC00004,0xBFC00000}, mask=2'b11, out_ready=1 every cycle -> out_valid=1 the next cycle with identical payload; steady 1 beat/cycle; occupancy stays 1.
- SKID=1: out_ready=0, send beats A (pc 0x100/0x104), B (0x108/0x10C), C (0x110/0x114) -> A and B accepted; occupancy=2; in_ready=0 during C; out_pc holds A. Then out_ready=1 -> A, B, C are delivered in order and C completes its handshake when in_ready returns to 1.
- Occupancy=2, assert flush together with in_valid=1 -> next cycle out_valid=0, occupancy=0, out_pc=0, in_ready=1; the offered beat never appears.
- Accept a beat with in_mask=2'b00 (pc 0x200/0x204) at occupancy 0 -> in_ready=1, handshake completes, out_valid stays 0, occupancy stays 0.
- Assert rst while occupancy=2 and out_ready=0 -> all outputs zero the next cycle, in_ready=1. Then exc={8'h00,8'h04}, mask=2'b01 -> exception bundle passes through unchanged.
- SKID=0: out_ready toggles 1,0,1,0 with in_valid=1 -> in_ready tracks !main.valid || out_ready combinationally; no beat is lost or duplicated across 8 beats.
